// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue/writeback slice: datapath width,
// ALU latency, control-word bit positions and the in-flight tracker entry.
// Imported by regfile_nr and alu_issue_wb.
package alu_pkg;

  localparam int W      = 8;
  localparam int LAT    = 2;
  localparam int NREG   = 4;
  localparam int AW     = $clog2(NREG);
  localparam int CTRL_W = 4;

  // Control-word bit positions understood by the pipelined ALU.
  localparam int CTRL_MUL_SEL = 0;
  localparam int CTRL_BHI     = 1;
  localparam int CTRL_SUB     = 2;

  // One slot of the in-flight tracker: which register the op will write
  // and the control word it was issued with (for echo checking).
  typedef struct packed {
    logic              valid;
    logic [AW-1:0]     rd;
    logic [CTRL_W-1:0] ctrl;
  } trk_entry_t;

  // Add/sub ops are the only ones whose carry-out is architecturally kept.
  function automatic logic ctrl_is_addsub(input logic [CTRL_W-1:0] ctrl);
    return !ctrl[CTRL_MUL_SEL];
  endfunction

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// regfile_nr
// NREG x W register file with asynchronous active-low reset.
// Ports:
//   clk, rst_n            clock / async reset (clears every register)
//   we, waddr, wdata      single write port, written on the rising edge
//   raddr1/rdata1         issue read port for operand A (combinational)
//   raddr2/rdata2         issue read port for operand B (combinational)
//   dbg_addr/dbg_data     debug read port (combinational)
module regfile_nr
  import alu_pkg::*;
#(
  parameter int W    = alu_pkg::W,
  parameter int NREG = alu_pkg::NREG,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [RA_W-1:0] raddr1,
  output logic [W-1:0]    rdata1,
  input  logic [RA_W-1:0] raddr2,
  output logic [W-1:0]    rdata2,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [W-1:0]    dbg_data
);

  logic [NREG-1:0][W-1:0] regs_q;
  logic [NREG-1:0][W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see only values committed at earlier edges; the issue logic's
  // hazard stall guarantees no read ever needs a same-edge write.
  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb
// In-order issue and writeback controller for a pipelined W-bit ALU.
// Instructions name two source registers and a destination; operands are
// read from the internal register file and registered onto the ALU inputs.
// A shift-register tracker of depth LAT+1 follows each op through the ALU
// and retires the result into the register file when it reaches the tail.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   instr_valid/instr_ready          issue handshake
//   instr_ctrl, instr_rs1/rs2/rd     instruction fields
//   alu_a, alu_b, alu_ctrl           registered ALU inputs
//   alu_result, alu_cout             ALU outputs
//   alu_ctrl_ret                     control word echoed by the ALU
//   wb_valid, wb_rd, wb_data         one-cycle writeback report
//   carry_flag                       carry of last retired add/sub
//   ctrl_err                         sticky echo-mismatch flag
//   busy                             any op in flight
//   dbg_addr/dbg_data                debug register read
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int W    = alu_pkg::W,
  parameter int NREG = alu_pkg::NREG,
  parameter int LAT  = alu_pkg::LAT,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_ctrl,
  input  logic [RA_W-1:0] instr_rs1,
  input  logic [RA_W-1:0] instr_rs2,
  input  logic [RA_W-1:0] instr_rd,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_cout,
  input  logic [3:0]      alu_ctrl_ret,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [W-1:0]    wb_data,
  output logic            carry_flag,
  output logic            ctrl_err,
  output logic            busy,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [W-1:0]    dbg_data
);

  // One extra slot beyond the ALU latency: the op sits in the tail during
  // the cycle its result is stable, and retires at the following edge.
  localparam int D = LAT + 1;

  trk_entry_t [D-1:0] trk_q;
  trk_entry_t [D-1:0] trk_d;
  trk_entry_t         tail;

  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic [W-1:0]    wb_data_q, wb_data_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;

  logic            hazard;
  logic            issue;
  logic [W-1:0]    rs1_data;
  logic [W-1:0]    rs2_data;

  assign tail = trk_q[D-1];

  regfile_nr #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (tail.valid),
    .waddr    (tail.rd),
    .wdata    (alu_result),
    .raddr1   (instr_rs1),
    .rdata1   (rs1_data),
    .raddr2   (instr_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // RAW check against every live slot, including the tail that retires at
  // this very edge: there is no bypass, so the reader waits one more edge
  // for the register file to hold the new value.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (trk_q[i].valid &&
          ((trk_q[i].rd == instr_rs1) || (trk_q[i].rd == instr_rs2))) begin
        hazard = 1'b1;
      end
    end
  end

  assign instr_ready = !hazard;
  assign issue       = instr_valid && instr_ready;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < D; i++) begin
      busy = busy | trk_q[i].valid;
    end
  end

  // The tracker shifts every clock; a bubble enters when nothing issues.
  always_comb begin
    trk_d[0] = '0;
    if (issue) begin
      trk_d[0].valid = 1'b1;
      trk_d[0].rd    = instr_rd;
      trk_d[0].ctrl  = instr_ctrl;
    end
    for (int i = 1; i < D; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  // Operands hold when idle; the ALU keeps recomputing the last op, which
  // is harmless because the matching tracker slot is invalid.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    if (issue) begin
      alu_a_d    = rs1_data;
      alu_b_d    = rs2_data;
      alu_ctrl_d = instr_ctrl;
    end
  end

  always_comb begin
    wb_valid_d = tail.valid;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    carry_d    = carry_q;
    err_d      = err_q;
    if (tail.valid) begin
      wb_rd_d   = tail.rd;
      wb_data_d = alu_result;
      if (ctrl_is_addsub(tail.ctrl)) begin
        carry_d = alu_cout;
      end
      if (alu_ctrl_ret != tail.ctrl) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign carry_flag = carry_q;
  assign ctrl_err   = err_q;

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- In-order issue and writeback controller that drives the pipelined 8-bit ALU and retires its results into a small register file.
- Accepts register-addressed instructions over a valid/ready handshake and reads operands from its internal register file.
- Drives the ALU's A/B/control inputs, tracks in-flight ops through the fixed ALU latency, and writes results back to the destination register.
- Stalls on read-after-write hazards and checks the control word the ALU echoes back against the one it issued.

Parameters:
- W, 8, data width; matches the ALU operand/result width.
- NREG, 4, number of registers; must be a power of 2, and register address width AW = log2(NREG).
- LAT, 2, ALU latency in clocks, from control capture to a stable ctrl_out.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted this cycle when high together with instr_valid.
- instr_ctrl  in  4  ALU control word, passed unchanged to the ALU.
- instr_rs1  in  AW  source register for operand A.
- instr_rs2  in  AW  source register for operand B.
- instr_rd  in  AW  destination register.
- alu_a  out  W  registered operand A to the ALU.
- alu_b  out  W  registered operand B to the ALU.
- alu_ctrl  out  4  registered control word to the ALU.
- alu_result  in  W  ALU_out from the ALU.
- alu_cout  in  1  Cout from the ALU.
- alu_ctrl_ret  in  4  ctrl_out echoed back by the ALU.
- wb_valid  out  1  one-cycle pulse: a register was written.
- wb_rd  out  AW  register written.
- wb_data  out  W  value written.
- carry_flag  out  1  Cout of the last retired add/sub.
- ctrl_err  out  1  sticky: echoed control word mismatched the issued one.
- busy  out  1  at least one op in flight.
- dbg_addr  in  AW  debug register-file read address.
- dbg_data  out  W  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - All registers = 0, tracker entries invalid.
  - alu_a, alu_b, alu_ctrl, wb_valid, wb_rd, wb_data, carry_flag, ctrl_err = 0.
  - busy = 0; instr_ready = 1 once reset is released.
- Tracker: shift register of depth D = LAT+1. Each entry holds {valid, rd, ctrl}, and it shifts every clock.
- Issue at edge E0 (instr_valid && instr_ready):
  - alu_a <= regs[rs1], alu_b <= regs[rs2], alu_ctrl <= instr_ctrl.
  - Tracker entry 0 <= {1, rd, ctrl}.
- No issue at an edge:
  - Tracker entry 0 <= invalid.
  - alu_a, alu_b, alu_ctrl hold their values; the ALU recomputes the same result, which is harmless because the entry is invalid.
- Retire at edge E0+D, when the tracker tail is valid:
  - regs[rd] <= alu_result; wb_valid=1, wb_rd, wb_data registered for one cycle.
  - If ctrl[0]==0 (add/sub path): carry_flag <= alu_cout. Otherwise carry_flag holds.
  - If alu_ctrl_ret != tail.ctrl: ctrl_err <= 1. ctrl_err stays set until reset.
- Retire with an invalid tail: wb_valid=0 and no register changes.
- Hazard rule: instr_ready = 0 if rs1 or rs2 equals the rd of ANY valid tracker entry, including the entry retiring this edge. There is no bypass; the stall lasts until that entry retires.
- instr_rd alone never stalls; in-order retirement preserves WAW ordering.
- Throughput: one instruction per clock with no hazards. A dependent op issues at the edge after its producer retires, giving a back-to-back dependency gap of D clocks.
- Register reads at issue see values written at earlier edges only; a same-edge write is impossible because of the stall rule.
- busy = OR of the valid bits across the tracker.
- Reset mid-flight: all in-flight ops are discarded and no writeback occurs.
- rs1 == rs2 is legal; rd == rs1 is legal (the read happens before the writeback).
- Widths: the result is W bits and no sign extension is done; the carry is taken only from alu_cout.

Decomposition:
- Shared package (alu_pkg):
  - W, LAT.
  - Control-bit field positions: CTRL_MUL_SEL = 0, CTRL_SUB = 2, CTRL_BHI = 1.
  - Tracker entry struct {valid, rd, ctrl}.
- Sub-module regfile_nr: NREG x W storage, async-reset, one write port, two issue read ports plus the debug read port.
- Tracker and hazard compare stay in the top module.

Test Plan:
- Reset, then regs preloaded via a writeback path (r1=0x05, r2=0x03).
  - Issue ctrl=0x0, rs1=1, rs2=2, rd=3.
  - Required: alu_a=0x05, alu_b=0x03 one edge later; wb_valid pulse D edges after issue; wb_rd=3, wb_data=ALU sum 0x08; carry_flag=0.
- RAW hazard: issue rd=3, then an op with rs1=3 offered on the next cycle.
  - Required: instr_ready=0 for D cycles; the second op issues at the edge after the first retires; its alu_a equals the new r3.
- Four independent ops on consecutive cycles.
  - Required: instr_ready stays 1; four consecutive wb_valid pulses in issue order; busy falls one cycle after the last retire.
- Multiply op (ctrl[0]=1) with carry_flag=1 beforehand.
  - Required: carry_flag stays 1 after the retire.
- Force alu_ctrl_ret != issued ctrl on one retire.
  - Required: ctrl_err=1 and stays 1 through later clean retires.
- Assert rst_n low with 2 ops in flight.
  - Required: all outputs 0 immediately; no wb_valid after release; dbg_data reads 0 for every register.
